// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide. Define SEQ_ALU_DIV_EN to include the divider.
module seq_alu #(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             flag,
   output logic             error
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   typedef enum logic [4:0] {
      OP_ADD   = 5'h00, OP_SUB  = 5'h01, OP_MUL  = 5'h02, OP_MULHU = 5'h03,
      OP_DIVU  = 5'h04, OP_REMU = 5'h05, OP_AND  = 5'h06, OP_OR    = 5'h07,
      OP_XOR   = 5'h08, OP_NOR  = 5'h09, OP_SLL  = 5'h0A, OP_SRL   = 5'h0B,
      OP_SRA   = 5'h0C, OP_SLT  = 5'h0D, OP_SLTU = 5'h0E, OP_EQ    = 5'h0F
   } op_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   b_q;
   logic [SHW-1:0]     cnt_q;
   logic               op_lo_q;
   logic               busy_q, valid_q, flag_q, error_q;
   logic [WIDTH-1:0]   result_q;

   logic [WIDTH:0]     add_w, sub_w, mul_sum;
   logic [WIDTH-1:0]   sc_res, fin_res;
   logic               sc_err, sc_carry, use_carry, sc_flag;
   logic               go_mul, go_div;
   logic [2*WIDTH-1:0] mul_acc, step_acc;
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]     div_rem, div_diff;
   logic [2*WIDTH-1:0] div_acc;
`endif

   always_comb begin
      add_w     = {1'b0, a} + {1'b0, b};
      sub_w     = {1'b0, a} - {1'b0, b};
      sc_res    = '0;
      sc_err    = 1'b0;
      sc_carry  = 1'b0;
      use_carry = 1'b0;
      go_mul    = 1'b0;
      go_div    = 1'b0;
      case (op_t'(opcode))
         OP_ADD:   begin sc_res = add_w[WIDTH-1:0]; sc_carry = add_w[WIDTH]; use_carry = 1'b1; end
         OP_SUB:   begin sc_res = sub_w[WIDTH-1:0]; sc_carry = sub_w[WIDTH]; use_carry = 1'b1; end
         OP_MUL, OP_MULHU: go_mul = 1'b1;
`ifdef SEQ_ALU_DIV_EN
         // Divide by zero completes immediately with the conventional RISC-style results.
         OP_DIVU:  if (b == '0) begin sc_res = '1; sc_err = 1'b1; end else go_div = 1'b1;
         OP_REMU:  if (b == '0) begin sc_res = a;  sc_err = 1'b1; end else go_div = 1'b1;
`endif
         OP_AND:   sc_res = a & b;
         OP_OR:    sc_res = a | b;
         OP_XOR:   sc_res = a ^ b;
         OP_NOR:   sc_res = ~(a | b);
         OP_SLL:   sc_res = a << b[SHW-1:0];
         OP_SRL:   sc_res = a >> b[SHW-1:0];
         OP_SRA:   sc_res = $signed(a) >>> b[SHW-1:0];
         OP_SLT:   sc_res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU:  sc_res = WIDTH'(a < b);
         OP_EQ:    sc_res = WIDTH'(a == b);
         default:  sc_err = 1'b1;
      endcase
      sc_flag = use_carry ? sc_carry : (sc_res == '0);

      // Multiplier in the low half shifts out as the product builds in the high half.
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_rem - {1'b0, b_q};
      div_acc  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      step_acc = (state_q == S_DIV) ? div_acc : mul_acc;
`else
      step_acc = mul_acc;
`endif
      fin_res = op_lo_q ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         op_lo_q  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         flag_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               valid_q <= 1'b0;
               if (start && (go_mul || go_div)) begin
                  state_q <= go_mul ? S_MUL : S_DIV;
                  busy_q  <= 1'b1;
                  acc_q   <= {{WIDTH{1'b0}}, a};
                  b_q     <= b;
                  op_lo_q <= opcode[0];
                  cnt_q   <= SHW'(WIDTH - 1);
               end else if (start) begin
                  state_q  <= S_DONE;
                  valid_q  <= 1'b1;
                  result_q <= sc_res;
                  flag_q   <= sc_flag;
                  error_q  <= sc_err;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= step_acc;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  valid_q  <= 1'b1;
                  result_q <= fin_res;
                  flag_q   <= (fin_res == '0);
                  error_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign valid  = valid_q;
   assign result = result_q;
   assign flag   = flag_q;
   assign error  = error_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table plus hand sequences; a scoreboard checks every valid pulse.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  opcode = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, valid, flag, error;
   logic [31:0] result;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
      .busy(busy), .valid(valid), .result(result), .flag(flag), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        flag;
      logic        err;
      int unsigned due;
   } exp_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        flag;
      logic        err;
      int unsigned lat;
   } vec_t;

   localparam int NV = 25;
   vec_t        vecs[NV];
   exp_t        q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst && valid) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_valid: got valid=1 with result %h, expected no valid", result);
         end else begin
            mon_e = q.pop_front();
            check("result", result, mon_e.res);
            check("flag", flag, mon_e.flag);
            check("error", error, mon_e.err);
            check("valid_cycle", cyc, mon_e.due);
         end
      end
   end

   // Called just after a negedge; returns at the negedge one cycle later.
   task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input logic fl, input logic er, input int unsigned lat);
      exp_t e;
      opcode = op; a = av; b = bv; start = 1'b1;
      e.res = res; e.flag = fl; e.err = er; e.due = cyc + lat;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL timeout: got %0d results outstanding, expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      vecs[0]  = '{5'h00, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1};
      vecs[1]  = '{5'h00, 32'h1,        32'h2,        32'h3,        1'b0, 1'b0, 1};
      vecs[2]  = '{5'h01, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b1, 1'b0, 1};
      vecs[3]  = '{5'h01, 32'h7,        32'h5,        32'h2,        1'b0, 1'b0, 1};
      vecs[4]  = '{5'h02, 32'h12345678, 32'h10,       32'h23456780, 1'b0, 1'b0, 33};
      vecs[5]  = '{5'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
      vecs[6]  = '{5'h02, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 33};
`ifdef SEQ_ALU_DIV_EN
      vecs[7]  = '{5'h04, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33};
      vecs[8]  = '{5'h05, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33};
      vecs[9]  = '{5'h04, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1};
      vecs[10] = '{5'h05, 32'd5,        32'd0,        32'd5,        1'b0, 1'b1, 1};
`else
      vecs[7]  = '{5'h04, 32'd100,      32'd7,        32'h0,        1'b1, 1'b1, 1};
      vecs[8]  = '{5'h05, 32'd100,      32'd7,        32'h0,        1'b1, 1'b1, 1};
      vecs[9]  = '{5'h04, 32'd5,        32'd0,        32'h0,        1'b1, 1'b1, 1};
      vecs[10] = '{5'h05, 32'd5,        32'd0,        32'h0,        1'b1, 1'b1, 1};
`endif
      vecs[11] = '{5'h06, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        1'b1, 1'b0, 1};
      vecs[12] = '{5'h07, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
      vecs[13] = '{5'h08, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1};
      vecs[14] = '{5'h09, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1};
      vecs[15] = '{5'h0A, 32'h1,        32'h21,       32'h2,        1'b0, 1'b0, 1};
      vecs[16] = '{5'h0B, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0, 1};
      vecs[17] = '{5'h0C, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0, 1};
      vecs[18] = '{5'h0D, 32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0, 1};
      vecs[19] = '{5'h0E, 32'h80000000, 32'h1,        32'h0,        1'b1, 1'b0, 1};
      vecs[20] = '{5'h0F, 32'h3,        32'h3,        32'h1,        1'b0, 1'b0, 1};
      vecs[21] = '{5'h0F, 32'h3,        32'h4,        32'h0,        1'b1, 1'b0, 1};
      vecs[22] = '{5'h15, 32'h1234,     32'h5678,     32'h0,        1'b1, 1'b1, 1};
      vecs[23] = '{5'h1F, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1};
      vecs[24] = '{5'h03, 32'h12345678, 32'h10,       32'h1,        1'b0, 1'b0, 33};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_result", result, 0);
      check("rst_flag", flag, 0);
      check("rst_error", error, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flag, vecs[i].err, vecs[i].lat);
         check("busy_after_start", busy, vecs[i].lat > 1);
         wait_done();
      end

      // MUL with a stray start mid-operation, then back-to-back launches from the valid cycle
      issue(5'h02, 32'h12345678, 32'h10, 32'h23456780, 1'b0, 1'b0, 33);
      for (int k = 2; k <= 32; k++) begin
         @(negedge clk);
         check("busy_mul", busy, 1);
         if (k == 5) begin opcode = 5'h00; a = 32'h1; b = 32'h1; start = 1'b1; end
         if (k == 6) start = 1'b0;
      end
      @(negedge clk);
      check("busy_done", busy, 0);
      check("valid_done", valid, 1);
      issue(5'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
      issue(5'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
      wait_done();

`ifdef SEQ_ALU_DIV_EN
      issue(5'h04, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
      repeat (32) @(negedge clk);
      issue(5'h05, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
      wait_done();
`endif

      // Reset in the middle of a long operation
      issue(5'h01, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b1, 1'b0, 1);
      wait_done();
      @(negedge clk);
`ifdef SEQ_ALU_DIV_EN
      opcode = 5'h04; a = 32'd100; b = 32'd7;
`else
      opcode = 5'h02; a = 32'h12345678; b = 32'h10;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", valid, 0);
      check("arst_result", result, 0);
      check("arst_flag", flag, 0);
      check("arst_error", error, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(5'h0D, 32'h80000000, 32'h1, 32'h1, 1'b0, 1'b0, 1);
      issue(5'h0E, 32'h80000000, 32'h1, 32'h0, 1'b1, 1'b0, 1);
      wait_done();

      // Reset during a valid cycle
      @(negedge clk);
      issue(5'h15, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1);
      check("valid_before_rst", valid, 1);
      rst = 1'b1;
      #1;
      check("arst2_valid", valid, 0);
      check("arst2_error", error, 0);
      check("arst2_flag", flag, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(5'h00, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1);
      wait_done();

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the multi-cycle CPU datapath. It captures operands on a start strobe and executes single-cycle logic/arithmetic ops or iterative shift-add multiply and restoring divide. It returns a registered result with a one-cycle valid pulse and a busy indication to the control FSM. Multiply and divide are integrated, so the block needs no external submodules.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- opcode  in  5  operation select, captured with start
- a  in  WIDTH  operand 1, captured with start
- b  in  WIDTH  operand 2, captured with start
- busy  out  1  multi-cycle op in progress; reset 0
- valid  out  1  one-cycle pulse, result/flag/error valid; reset 0
- result  out  WIDTH  registered result, held until next completion; reset 0
- flag  out  1  status bit, held with result; reset 0
- error  out  1  illegal opcode or divide-by-zero, held with result; reset 0

## Operation
- Opcodes:
  - 00000 ADD; 00001 SUB.
  - 00010 MUL, low WIDTH bits; 00011 MULHU, high WIDTH bits, unsigned.
  - 00100 DIVU quotient; 00101 REMU remainder.
  - 00110 AND; 00111 OR; 01000 XOR; 01001 NOR.
  - 01010 SLL; 01011 SRL; 01100 SRA, shift amount b[SHW-1:0].
  - 01101 SLT signed; 01110 SLTU; 01111 EQ. Compare ops return 0/1 zero-extended.
  - Any other opcode: result 0, error=1, single-cycle.
- flag:
  - ADD: carry-out.
  - SUB: borrow (a<b unsigned).
  - All other ops: result==0.
- FSM states:
  - IDLE: start with a single-cycle op goes to DONE; start with MUL/MULHU goes to MUL; start with DIVU/REMU and b≠0 goes to DIV.
  - MUL/DIV: WIDTH iterations, one per cycle, on a 2·WIDTH accumulator; go to DONE after the last iteration.
  - DONE: valid=1 for exactly this cycle. start here is accepted (back-to-back) with the same transitions as IDLE; otherwise go to IDLE.
- busy=1 exactly in MUL and DIV. start while busy=1 is ignored, and captured operands are not disturbed.
- Divide by zero is short-circuited to DONE: DIVU result all-ones, REMU result a, error=1.
- The internal accumulator/counter are not visible. result/flag/error update only on the DONE-entry edge.

## Timing
- Start sampled at edge E0.
- Single-cycle op: valid high in the cycle after E0 (latency 1). busy stays 0.
- MUL/DIV: busy high for WIDTH cycles after E0. valid high in cycle WIDTH+1 with busy=0 (latency WIDTH+1, i.e. 33 at WIDTH=32).
- Back-to-back: a start asserted during the valid cycle yields the next valid at the same latency, with no bubble.
- Reset mid-operation: on assertion, all outputs go to 0 immediately and the FSM goes to IDLE. The first start after deassertion is honoured.
- Outputs are driven from flops only; there is no combinational input-to-output path.

## Configuration
- SEQ_ALU_DIV_EN defined: DIV state, divider datapath and DIVU/REMU behave as above.
- SEQ_ALU_DIV_EN undefined: the divider logic is removed. DIVU/REMU are treated as illegal opcodes: single-cycle, result 0, error=1. All other behaviour is unchanged.

## Test plan
- ADD a=0xFFFFFFFF, b=1 → one cycle later: valid=1, result=0, flag=1, error=0, busy never high.
- MUL a=0x12345678, b=0x10 → busy for 32 cycles; valid at cycle 33 with result=0x23456780. MULHU a=b=0xFFFFFFFF → result 0xFFFFFFFE.
- DIVU a=100, b=7 → result 14 at latency 33. REMU with the same operands → result 2, flag=0. DIVU a=5, b=0 → result 0xFFFFFFFF, error=1 at latency 1.
- Start a MUL, pulse start with opcode ADD at cycle 5 → ignored; the MUL result is unchanged at cycle 33. A start in the valid cycle launches the next op with no bubble.
- Assert rst at cycle 10 of a DIVU → busy, valid, result, flag and error all 0 asynchronously. A following SLT with a=0x80000000, b=1 gives result 1; SLTU with the same operands gives result 0.
- Build without SEQ_ALU_DIV_EN; issue DIVU a=100, b=7 → latency 1, result 0, error=1. Opcode 10101 gives the same response in both builds.
